lsu: RTL and testbench

- Per-thread load/store unit: turns a decoded LDR/STR into a valid/ready transaction on the data-memory port.
- Produces `lsu_result`, which the thread's register file writes back during UPDATE.
- Sits between the decoder/register file (address and store data come from `rs_data`/`rt_data`) and the memory controller.
- The core scheduler polls `lsu_state` to leave WAIT.

---
 rtl/gpu_pkg.sv | 21 ++
 rtl/lsu.sv | 121 ++++++++++++
 tb/tb_lsu.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/gpu_pkg.sv
// Shared GPU types: the core scheduler state and the LSU state encoding.
package gpu_pkg;

    typedef enum logic [2:0] {
        CORE_IDLE    = 3'b000,
        CORE_FETCH   = 3'b001,
        CORE_DECODE  = 3'b010,
        CORE_REQUEST = 3'b011,
        CORE_WAIT    = 3'b100,
        CORE_EXECUTE = 3'b101,
        CORE_UPDATE  = 3'b110,
        CORE_DONE    = 3'b111
    } core_state_t;

    typedef enum logic [1:0] {
        LSU_IDLE       = 2'b00,
        LSU_REQUESTING = 2'b01,
        LSU_DONE       = 2'b11
    } lsu_state_t;

endpackage

// File: rtl/lsu.sv
// Per-thread load/store unit: one LDR/STR becomes one valid/ready memory transaction.
// Optional LSU_TIMEOUT_EN: aborts a request after TIMEOUT_CYCLES and flags lsu_error.
module lsu
    import gpu_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  core_state_t           core_state,
    input  logic                  mem_read_en,
    input  logic                  mem_write_en,
    input  logic [DATA_WIDTH-1:0] rs_data,
    input  logic [DATA_WIDTH-1:0] rt_data,
    output logic                  mem_read_valid,
    output logic [ADDR_WIDTH-1:0] mem_read_address,
    input  logic                  mem_read_ready,
    input  logic [DATA_WIDTH-1:0] mem_read_data,
    output logic                  mem_write_valid,
    output logic [ADDR_WIDTH-1:0] mem_write_address,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    input  logic                  mem_write_ready,
`ifdef LSU_TIMEOUT_EN
    output logic                  lsu_error,
`endif
    output lsu_state_t            lsu_state,
    output logic [DATA_WIDTH-1:0] lsu_result
);

    lsu_state_t            r_state, w_state_nxt;
    logic                  r_is_load;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_result;
    logic                  w_start;
    logic                  w_hs;
    logic                  w_timeout;

    assign w_start = enable && (r_state == LSU_IDLE) && (core_state == CORE_REQUEST)
                     && (mem_read_en || mem_write_en);
    // Valid is implied by REQUESTING, so ready outside a request never counts.
    assign w_hs    = enable && (r_state == LSU_REQUESTING)
                     && (r_is_load ? mem_read_ready : mem_write_ready);

`ifdef LSU_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] r_cnt;
    logic          r_error;

    // Handshake has priority over an expiring counter.
    assign w_timeout = enable && (r_state == LSU_REQUESTING) && !w_hs
                       && (r_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_error <= 1'b0;
        end else if (w_start) begin
            r_cnt   <= '0;
            r_error <= 1'b0;
        end else if (w_timeout) begin
            r_error <= 1'b1;
        end else if (enable && (r_state == LSU_REQUESTING) && !w_hs) begin
            r_cnt   <= r_cnt + 1'b1;
        end
    end

    assign lsu_error = r_error;
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= LSU_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!enable) begin
            w_state_nxt = LSU_IDLE;
        end else begin
            case (r_state)
                LSU_IDLE:       if (w_start) w_state_nxt = LSU_REQUESTING;
                LSU_REQUESTING: if (w_hs || w_timeout) w_state_nxt = LSU_DONE;
                LSU_DONE:       if (core_state == CORE_UPDATE) w_state_nxt = LSU_IDLE;
                default:        w_state_nxt = LSU_IDLE;
            endcase
        end
    end

    // A load wins when both enables are set; store data is only captured for stores.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_is_load <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_result  <= '0;
        end else begin
            if (w_start) begin
                r_is_load <= mem_read_en;
                r_addr    <= ADDR_WIDTH'(rs_data);
                if (!mem_read_en) r_wdata <= rt_data;
            end
            if (w_hs && r_is_load)      r_result <= mem_read_data;
            if (w_timeout && r_is_load) r_result <= '1;
        end
    end

    assign mem_read_valid    = (r_state == LSU_REQUESTING) && r_is_load;
    assign mem_write_valid   = (r_state == LSU_REQUESTING) && !r_is_load;
    assign mem_read_address  = r_addr;
    assign mem_write_address = r_addr;
    assign mem_write_data    = r_wdata;
    assign lsu_state         = r_state;
    assign lsu_result        = r_result;

endmodule

// File: tb/tb_lsu.sv
// Randomized transaction-level bench for lsu; expected values come from a simple
// per-transaction model (last loaded value, what the port should show while pending).
module tb_lsu;
    import gpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    core_state_t core_state = CORE_IDLE;
    logic        mem_read_en = 1'b0, mem_write_en = 1'b0;
    logic [7:0]  rs_data = '0, rt_data = '0;
    logic        mem_read_valid, mem_write_valid;
    logic [7:0]  mem_read_address, mem_write_address, mem_write_data;
    logic        mem_read_ready = 1'b0, mem_write_ready = 1'b0;
    logic [7:0]  mem_read_data = '0;
    lsu_state_t  lsu_state;
    logic [7:0]  lsu_result;
`ifdef LSU_TIMEOUT_EN
    logic        lsu_error;
`endif

    int checks = 0;
    int errs   = 0;
    logic [7:0] exp_result = 8'h00;

    lsu #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .core_state(core_state),
        .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
        .rs_data(rs_data), .rt_data(rt_data),
        .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
        .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
        .mem_write_valid(mem_write_valid), .mem_write_address(mem_write_address),
        .mem_write_data(mem_write_data), .mem_write_ready(mem_write_ready),
`ifdef LSU_TIMEOUT_EN
        .lsu_error(lsu_error),
`endif
        .lsu_state(lsu_state), .lsu_result(lsu_result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        core_state      = CORE_FETCH;
        mem_read_en     = 1'b0;
        mem_write_en    = 1'b0;
        mem_read_ready  = 1'b0;
        mem_write_ready = 1'b0;
    endtask

    // kind: 0 load, 1 store, 2 both enables (behaves as load). drop: pull enable mid-request.
    task automatic do_txn(input int kind, input logic [7:0] addr, input logic [7:0] wd,
                          input logic [7:0] rdata, input int delay, input bit drop);
        bit is_ld = (kind != 1);
        core_state      = CORE_REQUEST;
        mem_read_en     = (kind != 1);
        mem_write_en    = (kind != 0);
        rs_data         = addr;
        rt_data         = wd;
        // Ready while nothing is pending must be ignored.
        mem_read_ready  = 1'($urandom_range(0, 1));
        mem_write_ready = mem_read_ready;
        mem_read_data   = 8'($urandom);
        @(negedge clk);
        core_state      = CORE_WAIT;
        mem_read_ready  = 1'b0;
        mem_write_ready = 1'b0;
        chk("start_state", 32'(lsu_state), 32'(LSU_REQUESTING));
`ifdef LSU_TIMEOUT_EN
        chk("err_clear", 32'(lsu_error), 32'd0);
`endif
        if (drop) begin
            enable          = 1'b0;
            mem_read_ready  = 1'b1;
            mem_write_ready = 1'b1;
            @(negedge clk);
            chk("drop_state", 32'(lsu_state), 32'(LSU_IDLE));
            chk("drop_rv", 32'(mem_read_valid), 32'd0);
            chk("drop_wv", 32'(mem_write_valid), 32'd0);
            chk("drop_result", 32'(lsu_result), 32'(exp_result));
            enable = 1'b1;
            idle_inputs();
            @(negedge clk);
            return;
        end
        for (int i = 0; i <= delay; i++) begin
            chk("rv", 32'(mem_read_valid), 32'(is_ld));
            chk("wv", 32'(mem_write_valid), 32'(!is_ld));
            if (is_ld) chk("raddr", 32'(mem_read_address), 32'(addr));
            else begin
                chk("waddr", 32'(mem_write_address), 32'(addr));
                chk("wdata", 32'(mem_write_data), 32'(wd));
            end
            if (i == delay) begin
                mem_read_ready  = 1'b1;
                mem_write_ready = 1'b1;
                mem_read_data   = rdata;
            end else begin
                mem_read_data   = 8'($urandom);
            end
            @(negedge clk);
        end
        mem_read_ready  = 1'b0;
        mem_write_ready = 1'b0;
        mem_read_data   = 8'($urandom);
        if (is_ld) exp_result = rdata;
        chk("done_state", 32'(lsu_state), 32'(LSU_DONE));
        chk("done_rv", 32'(mem_read_valid), 32'd0);
        chk("done_wv", 32'(mem_write_valid), 32'd0);
        chk("done_result", 32'(lsu_result), 32'(exp_result));
        core_state = CORE_UPDATE;
        #1;
        chk("upd_state", 32'(lsu_state), 32'(LSU_DONE));
        chk("upd_result", 32'(lsu_result), 32'(exp_result));
        @(negedge clk);
        idle_inputs();
        chk("post_state", 32'(lsu_state), 32'(LSU_IDLE));
        chk("post_result", 32'(lsu_result), 32'(exp_result));
        @(negedge clk);
    endtask

    initial begin
        #12;
        chk("rst_state", 32'(lsu_state), 32'(LSU_IDLE));
        chk("rst_rv", 32'(mem_read_valid), 32'd0);
        chk("rst_wv", 32'(mem_write_valid), 32'd0);
        chk("rst_result", 32'(lsu_result), 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        enable = 1'b1;
        idle_inputs();
        @(negedge clk);

        do_txn(0, 8'h10, 8'h00, 8'hA5, 0, 1'b0);
        do_txn(1, 8'h20, 8'h3C, 8'h5A, 5, 1'b0);
        do_txn(2, 8'h33, 8'h77, 8'h6B, 2, 1'b0);
        do_txn(0, 8'h44, 8'h00, 8'h99, 3, 1'b1);

        for (int n = 0; n < 30; n++) begin
            do_txn(int'($urandom_range(0, 2)), 8'($urandom), 8'($urandom), 8'($urandom),
                   int'($urandom_range(0, 6)), ($urandom_range(0, 7) == 0));
        end

        // Asynchronous reset two cycles into a load.
        do_txn(0, 8'h51, 8'h00, 8'hC3, 0, 1'b0);
        core_state     = CORE_REQUEST;
        mem_read_en    = 1'b1;
        rs_data        = 8'h66;
        @(negedge clk);
        core_state = CORE_WAIT;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        exp_result = 8'h00;
        chk("arst_state", 32'(lsu_state), 32'(LSU_IDLE));
        chk("arst_rv", 32'(mem_read_valid), 32'd0);
        chk("arst_addr", 32'(mem_read_address), 32'd0);
        chk("arst_result", 32'(lsu_result), 32'd0);
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

`ifdef LSU_TIMEOUT_EN
        core_state  = CORE_REQUEST;
        mem_read_en = 1'b1;
        rs_data     = 8'h7E;
        @(negedge clk);
        core_state = CORE_WAIT;
        for (int i = 0; i < 4; i++) begin
            chk("to_rv", 32'(mem_read_valid), 32'd1);
            @(negedge clk);
        end
        exp_result = 8'hFF;
        chk("to_state", 32'(lsu_state), 32'(LSU_DONE));
        chk("to_rv_drop", 32'(mem_read_valid), 32'd0);
        chk("to_err", 32'(lsu_error), 32'd1);
        chk("to_result", 32'(lsu_result), 32'(exp_result));
        core_state = CORE_UPDATE;
        @(negedge clk);
        idle_inputs();
        chk("to_err_hold", 32'(lsu_error), 32'd1);
        @(negedge clk);
        do_txn(0, 8'h12, 8'h00, 8'h34, 1, 1'b0);
`endif

        do_txn(1, 8'hF0, 8'h0F, 8'h00, 1, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errs);
        $finish;
    end

endmodule
